// File: rtl/ide_pkg.sv
// Shared types and constants for the PIO-mode IDE bus sequencer.
package ide_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    RECOVER
  } state_t;

  localparam logic [1:0] CS_NONE = 2'b11;
  localparam logic [1:0] CS_CMD  = 2'b10;
  localparam logic [1:0] CS_CTL  = 2'b01;

  localparam int DEF_T_SETUP     = 3;
  localparam int DEF_T_PULSE     = 8;
  localparam int DEF_T_HOLD      = 2;
  localparam int DEF_T_RECOVER   = 4;
  localparam int DEF_T_IORDY_MAX = 200;

  // Active-low chip select for the register block chosen by addr[3].
  function automatic logic [1:0] cs_for(input logic blk);
    return blk ? CS_CTL : CS_CMD;
  endfunction

endpackage

// File: rtl/ide_timer.sv
// Loadable 8-bit down-counter shared by every phase of the IDE sequencer.
module ide_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/ide_pio_ctl.sv
// PIO-mode ATA/IDE register access sequencer with programmable timing
// and a bounded IORDY wait.
module ide_pio_ctl
  import ide_pkg::*;
#(
  parameter int T_SETUP     = DEF_T_SETUP,
  parameter int T_PULSE     = DEF_T_PULSE,
  parameter int T_HOLD      = DEF_T_HOLD,
  parameter int T_RECOVER   = DEF_T_RECOVER,
  parameter int T_IORDY_MAX = DEF_T_IORDY_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy,
  input  logic [15:0] ide_data_in,
  output logic [15:0] ide_data_out,
  output logic        ide_data_oe,
  input  logic        ide_iordy,
  output logic        ide_dior,
  output logic        ide_diow,
  output logic [1:0]  ide_cs,
  output logic [2:0]  ide_da
);

  localparam logic [7:0] LD_SETUP   = 8'(T_SETUP - 1);
  localparam logic [7:0] LD_PULSE   = 8'(T_PULSE - 1);
  localparam logic [7:0] LD_HOLD    = 8'(T_HOLD - 1);
  localparam logic [7:0] LD_RECOVER = 8'(T_RECOVER - 1);
  localparam logic [7:0] LD_IORDY   = 8'(T_IORDY_MAX - 1);

  state_t state;
  logic   we_q;
  logic   waiting;
  logic   err_pending;
  logic   tmr_load;
  logic [7:0] tmr_val;
  logic   tmr_zero;
  logic   pulse_exit;
  logic   pulse_wait;
  logic   timeout;

  // Once the nominal pulse expires with IORDY low, the timer is reloaded
  // as the wait counter; IORDY wins over a simultaneous timeout.
  assign pulse_wait = (state == PULSE) && !waiting && tmr_zero && !ide_iordy;
  assign timeout    = (state == PULSE) && waiting && tmr_zero && !ide_iordy;
  assign pulse_exit = (state == PULSE) &&
                      ((waiting && (ide_iordy || tmr_zero)) ||
                       (!waiting && tmr_zero && ide_iordy));

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = 8'd0;
    case (state)
      IDLE:    if (req)      begin tmr_load = 1'b1; tmr_val = LD_SETUP;   end
      SETUP:   if (tmr_zero) begin tmr_load = 1'b1; tmr_val = LD_PULSE;   end
      PULSE: begin
        if (pulse_wait)      begin tmr_load = 1'b1; tmr_val = LD_IORDY;   end
        else if (pulse_exit) begin tmr_load = 1'b1; tmr_val = LD_HOLD;    end
      end
      HOLD:    if (tmr_zero) begin tmr_load = 1'b1; tmr_val = LD_RECOVER; end
      default: ;
    endcase
  end

  ide_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      waiting      <= 1'b0;
      err_pending  <= 1'b0;
      rdata        <= 16'h0000;
      ack          <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      ide_data_out <= 16'h0000;
      ide_data_oe  <= 1'b0;
      ide_dior     <= 1'b1;
      ide_diow     <= 1'b1;
      ide_cs       <= CS_NONE;
      ide_da       <= 3'd0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q   <= we;
            ide_cs <= cs_for(addr[3]);
            ide_da <= addr[2:0];
            busy   <= 1'b1;
            if (we) begin
              ide_data_oe  <= 1'b1;
              ide_data_out <= wdata;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          if (tmr_zero) begin
            waiting <= 1'b0;
            if (we_q) ide_diow <= 1'b0;
            else      ide_dior <= 1'b0;
            state <= PULSE;
          end
        end
        PULSE: begin
          if (pulse_wait) begin
            waiting <= 1'b1;
          end else if (pulse_exit) begin
            waiting  <= 1'b0;
            ide_dior <= 1'b1;
            ide_diow <= 1'b1;
            if (timeout) err_pending <= 1'b1;
            if (!we_q)   rdata <= ide_data_in;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (tmr_zero) begin
            ide_cs      <= CS_NONE;
            ide_data_oe <= 1'b0;
            state       <= RECOVER;
          end
        end
        RECOVER: begin
          if (tmr_zero) begin
            ack         <= 1'b1;
            err         <= err_pending;
            err_pending <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ide_pio_ctl.sv
// Directed, table-driven bench for ide_pio_ctl at default timing.
module tb_ide_pio_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;
  logic [15:0] ide_data_in;
  logic [15:0] ide_data_out;
  logic        ide_data_oe;
  logic        ide_iordy;
  logic        ide_dior;
  logic        ide_diow;
  logic [1:0]  ide_cs;
  logic [2:0]  ide_da;

  int n_compared = 0;
  int n_mismatched = 0;

  // Edge index (relative to acceptance) where the nominal pulse ends.
  localparam int NOMINAL_END = 11;

  always #5 clk = ~clk;

  ide_pio_ctl dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .ack          (ack),
    .err          (err),
    .busy         (busy),
    .ide_data_in  (ide_data_in),
    .ide_data_out (ide_data_out),
    .ide_data_oe  (ide_data_oe),
    .ide_iordy    (ide_iordy),
    .ide_dior     (ide_dior),
    .ide_diow     (ide_diow),
    .ide_cs       (ide_cs),
    .ide_da       (ide_da)
  );

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] dev;
    int          ext;
    int          cs;
    int          da;
    int          dior_low;
    int          diow_low;
    int          oe_cycles;
    int          ack_at;
    int          rdata;
    int          err;
  } vec_t;

  typedef struct {
    int cs, da, dior_low, diow_low, oe_cycles, ack_at, rdata, err;
    int busy_at_ack, ack_after, violations, data_bad;
  } obs_t;

  task automatic check_output(input string name, input int act, input int exp);
    n_compared++;
    if (act != exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one access and observe it sample by sample until one cycle past ack.
  task automatic apply_stimulus(input logic w, input logic [3:0] a, input logic [15:0] wd,
                                input logic [15:0] dev, input int ext, output obs_t o);
    o = '{default: 0};
    o.ack_at = -1;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = wd; ide_data_in = dev; ide_iordy = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      if (o.ack_at >= 0) begin
        o.ack_after = int'(ack);
        break;
      end
      if (j == 0) begin o.cs = int'(ide_cs); o.da = int'(ide_da); end
      if (!ide_dior) o.dior_low++;
      if (!ide_diow) o.diow_low++;
      if (ide_data_oe) o.oe_cycles++;
      if (ide_data_oe && ide_data_out != wd) o.data_bad++;
      if ((!ide_dior && !ide_diow) || ((!ide_dior || !ide_diow) && ide_cs == 2'b11))
        o.violations++;
      if (ack) begin
        o.ack_at = j;
        o.rdata = int'(rdata);
        o.err = int'(err);
        o.busy_at_ack = int'(busy);
      end
      ide_iordy = !((j + 1) >= NOMINAL_END && (j + 1) < NOMINAL_END + ext);
    end
    ide_iordy = 1'b1;
  endtask

  vec_t  vecs[6];
  obs_t  o;
  int    ack_at;
  int    ack_count;
  int    da_bad;
  int    diow_seen;

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 4'h0; wdata = 16'h0000;
    ide_data_in = 16'h0000; ide_iordy = 1'b1;

    vecs[0] = '{1'b0, 4'h7, 16'h0000, 16'h0050, 0,    2'b10, 7, 8,   0,  0,  17,  16'h0050, 0};
    vecs[1] = '{1'b1, 4'hE, 16'h0004, 16'h1234, 0,    2'b01, 6, 0,   8,  13, 17,  16'h0050, 0};
    vecs[2] = '{1'b0, 4'h0, 16'h0000, 16'hBEEF, 5,    2'b10, 0, 13,  0,  0,  22,  16'hBEEF, 0};
    vecs[3] = '{1'b0, 4'h9, 16'h0000, 16'h00A5, 1000, 2'b01, 1, 208, 0,  0,  217, 16'h00A5, 1};
    vecs[4] = '{1'b1, 4'h3, 16'hCAFE, 16'h7777, 0,    2'b10, 3, 0,   8,  13, 17,  16'h00A5, 0};
    vecs[5] = '{1'b1, 4'h8, 16'h5A5A, 16'h0000, 2,    2'b01, 0, 0,   10, 15, 19,  16'h00A5, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset dior", int'(ide_dior), 1);
    check_output("reset diow", int'(ide_diow), 1);
    check_output("reset cs", int'(ide_cs), 2'b11);
    check_output("reset da", int'(ide_da), 0);
    check_output("reset data_out", int'(ide_data_out), 0);
    check_output("reset oe", int'(ide_data_oe), 0);
    check_output("reset rdata", int'(rdata), 0);
    check_output("reset ack", int'(ack), 0);
    check_output("reset err", int'(err), 0);
    check_output("reset busy", int'(busy), 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].dev, vecs[i].ext, o);
      $display("[TB] vector %0d", i);
      check_output("cs", o.cs, vecs[i].cs);
      check_output("da", o.da, vecs[i].da);
      check_output("dior low cycles", o.dior_low, vecs[i].dior_low);
      check_output("diow low cycles", o.diow_low, vecs[i].diow_low);
      check_output("oe cycles", o.oe_cycles, vecs[i].oe_cycles);
      check_output("ack latency", o.ack_at, vecs[i].ack_at);
      check_output("rdata", o.rdata, vecs[i].rdata);
      check_output("err", o.err, vecs[i].err);
      check_output("busy at ack", o.busy_at_ack, 0);
      check_output("ack single pulse", o.ack_after, 0);
      check_output("strobe exclusivity", o.violations, 0);
      check_output("write data stable", o.data_bad, 0);
    end

    // Request during busy is ignored; request during ack is accepted.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 4'h1; ide_data_in = 16'h1111; ide_iordy = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    ack_at = -1; da_bad = 0; diow_seen = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (j == 5) begin req = 1'b1; we = 1'b1; addr = 4'hF; wdata = 16'h9999; end
      else if (j == 6) req = 1'b0;
      if (ide_da != 3'd1) da_bad++;
      if (!ide_diow) diow_seen++;
      if (ack) begin
        ack_at = j;
        check_output("b2b first rdata", int'(rdata), 16'h1111);
        req = 1'b1; we = 1'b0; addr = 4'h2; ide_data_in = 16'h2222;
        break;
      end
    end
    check_output("busy req ignored ack", ack_at, 17);
    check_output("busy req ignored da", da_bad, 0);
    check_output("busy req ignored diow", diow_seen, 0);
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check_output("b2b busy", int'(busy), 1);
    check_output("b2b cs", int'(ide_cs), 2'b10);
    check_output("b2b da", int'(ide_da), 2);
    check_output("b2b ack low", int'(ack), 0);
    ack_at = -1;
    for (int j = 1; j < 100; j++) begin
      @(negedge clk);
      if (ack) begin ack_at = j; break; end
    end
    check_output("b2b second ack", ack_at, 17);
    check_output("b2b second rdata", int'(rdata), 16'h2222);

    // Reset asserted while the write strobe is low.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 4'h4; wdata = 16'h5555;
    @(posedge clk);
    #1 req = 1'b0;
    for (int j = 0; j < 6; j++) @(negedge clk);
    check_output("pre-reset diow", int'(ide_diow), 0);
    reset = 1'b1;
    @(negedge clk);
    check_output("mid reset dior", int'(ide_dior), 1);
    check_output("mid reset diow", int'(ide_diow), 1);
    check_output("mid reset cs", int'(ide_cs), 2'b11);
    check_output("mid reset oe", int'(ide_data_oe), 0);
    check_output("mid reset busy", int'(busy), 0);
    check_output("mid reset rdata", int'(rdata), 0);
    reset = 1'b0;
    ack_count = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (ack) ack_count++;
    end
    check_output("no ack after reset", ack_count, 0);
    check_output("idle after reset", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/ide_pio_ctl.md
# ide_pio_ctl

PIO-mode ATA/IDE bus sequencer between the CPU's disk controller logic and the `ide_*` pins of the `pdp11` core. It accepts one register read or write at a time over a pulse/ack handshake and drives chip-select, address, strobes and data-bus enable with programmable setup, pulse, hold and recovery times. It also honours IORDY with a bounded wait.

## Interface

Parameters:
- `T_SETUP`, default 3: cycles with CS/DA (and write data) valid before the strobe falls; legal range 1..15.
- `T_PULSE`, default 8: minimum strobe-low cycles; legal range 1..15.
- `T_HOLD`, default 2: cycles with strobe high while CS/DA/data are still held; legal range 1..15.
- `T_RECOVER`, default 4: cycles with CS released before the next access may start; legal range 1..15.
- `T_IORDY_MAX`, default 200: maximum extra strobe-low cycles while IORDY is low; legal range 1..255.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous reset, active-high.
- `req`, in, 1: single-cycle request strobe.
- `we`, in, 1: 1 = write, 0 = read; sampled together with `req`.
- `addr`, in, 4: `{blk, da[2:0]}`. `blk` 0 selects the command block (CS0), 1 selects the control block (CS1).
- `wdata`, in, 16: write data; sampled together with `req`.
- `rdata`, out, 16: read data; valid while `ack` is high and held until the next read completes.
- `ack`, out, 1: one-cycle completion pulse.
- `err`, out, 1: IORDY timeout; valid with `ack`.
- `busy`, out, 1: an access is in progress.
- `ide_data_in`, in, 16: IDE data bus input.
- `ide_data_out`, out, 16: IDE data bus output.
- `ide_data_oe`, out, 1: output enable for `ide_data_out`. The pad tristate lives at top level.
- `ide_iordy`, in, 1: device ready, active-high. The input is already synchronised.
- `ide_dior`, out, 1: read strobe, active-low.
- `ide_diow`, out, 1: write strobe, active-low.
- `ide_cs`, out, 2: chip selects, active-low; CS0 is bit 0.
- `ide_da`, out, 3: device register address.

## Operation

- All outputs are registered.
- Reset values: `ide_dior=1`, `ide_diow=1`, `ide_cs=2'b11`, `ide_da=0`, `ide_data_out=0`, `ide_data_oe=0`, `rdata=0`, `ack=0`, `err=0`, `busy=0`. The state is IDLE.
- **IDLE:** when `req=1` at an edge, latch `we`, `addr` and `wdata`, go to SETUP, and set `busy=1`. `req` is ignored while `busy=1`; there is no queueing.
- **SETUP** (T_SETUP cycles):
  - `ide_cs` = `2'b10` if `blk=0`, `2'b01` if `blk=1`.
  - `ide_da` = `da`.
  - For writes, `ide_data_oe=1` and `ide_data_out=wdata`.
- **PULSE** (at least T_PULSE cycles): `ide_dior=0` (read) or `ide_diow=0` (write).
  - After T_PULSE cycles, if `ide_iordy=0`, remain in PULSE, incrementing the wait counter.
  - Leave PULSE at the first edge where `ide_iordy=1`, or when the wait counter reaches T_IORDY_MAX. The timeout sets a sticky `err_pending`.
  - On reads, `ide_data_in` is captured into `rdata` at the exiting edge.
- **HOLD** (T_HOLD cycles): strobe deasserted. CS, DA and the write data/oe are held.
- **RECOVER** (T_RECOVER cycles): `ide_cs=2'b11`, `ide_data_oe=0`. DA is held.
- **Completion:** at the edge leaving RECOVER, return to IDLE with `ack=1` for one cycle, `err=err_pending`, `busy=0`. `err_pending` is cleared at that edge.
- **Back-to-back:** a `req` sampled during the `ack` cycle is accepted, so the next SETUP begins the cycle after `ack`.
- **Reset mid-access:** all outputs return to reset values at that edge. No `ack` is issued and `rdata` is cleared.
- **Strobe exclusivity:** `ide_dior` and `ide_diow` are never low simultaneously. Neither strobe is low while `ide_cs=2'b11`.

## Timing

- N = T_SETUP + T_PULSE + W + T_HOLD + T_RECOVER, where W is the IORDY extension, 0..T_IORDY_MAX.
- Request at edge E0 → `busy` high from E0 to E0+N; `ack` high during the cycle after edge E0+N.
- With defaults and IORDY high, N=17, so `ack` appears 17 cycles after acceptance.
- The strobe is low for exactly T_PULSE+W cycles.
- Write data is stable from SETUP entry through the last HOLD cycle.

## Structure

- **Package `ide_pkg`:**
  - state enum IDLE/SETUP/PULSE/HOLD/RECOVER;
  - CS encodings `CS_NONE=2'b11`, `CS_CMD=2'b10`, `CS_CTL=2'b01`;
  - default timing constants.
- **Sub-module `ide_timer`:** a loadable 8-bit down-counter with a `zero` flag. One instance is shared by all phases and is reloaded on every state transition. The IORDY wait counter may reuse it.

## Test plan

- **Default-timing read:** `req`, `we=0`, `addr=4'h7`, device drives `16'h0050` → `ide_cs=2'b10`, `ide_da=7`, `ide_dior` low 8 cycles, `ack` 17 cycles after acceptance, `rdata=16'h0050`, `err=0`.
- **Control-block write:** `we=1`, `addr=4'hE`, `wdata=16'h0004` → `ide_cs=2'b01`, `ide_da=6`, `ide_data_oe=1` from SETUP through HOLD, `ide_diow` low 8 cycles, `ide_dior` stays high.
- **IORDY extension:** `ide_iordy` held low 5 cycles past the nominal pulse → strobe low 13 cycles, `ack` at cycle 22, `err=0`.
- **IORDY timeout:** `ide_iordy` stuck low → strobe low T_PULSE+200 cycles, then `ack=1` with `err=1`. The next access reports `err=0`.
- **Back-to-back and busy handling:** second `req` asserted while `busy=1` → ignored. `req` asserted during the `ack` cycle → accepted, CS reasserted the following cycle after the full recovery.
- **Reset mid-access:** assert `reset` during PULSE → next cycle strobes high, `ide_cs=2'b11`, `ide_data_oe=0`, `busy=0`, and no `ack` ever issued.
